// File: rtl/boa_rst_pkg.sv
// Shared types for the reset/power sequencer: FSM state and reset-cause
// encodings, plus the cause priority helper.
package boa_rst_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    SHDN  = 2'd2
  } rst_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_BTN  = 2'b01,
    CAUSE_PMU  = 2'b10,
    CAUSE_WAKE = 2'b11
  } rst_cause_t;

  // PMU outranks the button, which outranks wake, when sources coincide.
  function automatic rst_cause_t pick_cause(input logic pmu, input logic btn);
    if (pmu) begin
      return CAUSE_PMU;
    end else if (btn) begin
      return CAUSE_BTN;
    end
    return CAUSE_WAKE;
  endfunction

endpackage

// File: rtl/boa_debounce.sv
// Button conditioner: sync_stages-deep synchroniser followed by a debounce
// counter. The output flips only after the synchronised input has disagreed
// with it for db_len consecutive cycles; any agreement clears the counter.
module boa_debounce #(
  parameter int unsigned db_len      = 12000,
  parameter int unsigned sync_stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int unsigned CW = $clog2(db_len + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(db_len - 1);

  logic [sync_stages-1:0] sync_q;
  logic [sync_stages-1:0] sync_d;
  logic                   synced;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   out_q;
  logic                   out_d;

  assign sync_d = {sync_q[sync_stages-2:0], in};
  assign synced = sync_q[sync_stages-1];
  assign out    = out_q;

  // Count disagreement cycles; flip the output on the last one.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (synced != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser chain, counter and debounced output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: rtl/boa_rst_ctrl.sv
// Reset and power sequencer ahead of the main SoC. Turns the reset button,
// optional wake button and PMU requests into a stretched core reset and a
// clock-hold shutdown, and records the cause of the last reset.
// Optional feature macro: BOA_RST_WAKE_EN (wake button exits SHDN).
module boa_rst_ctrl
  import boa_rst_pkg::*;
#(
  parameter int unsigned rst_len     = 3,
  parameter int unsigned db_len      = 12000,
  parameter int unsigned sync_stages = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_rst,
  input  logic       btn_wake,
  input  logic       pmu_rst_req,
  input  logic       pmu_shdn_req,
  output logic       core_rst,
  output logic       shdn,
  output logic [1:0] rst_cause,
  output logic [1:0] state_dbg
);

  localparam int unsigned CW = $clog2(rst_len + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(rst_len);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  rst_state_t    state_q;
  rst_state_t    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  rst_cause_t    cause_q;
  rst_cause_t    cause_d;
  logic          core_rst_q;
  logic          shdn_q;

  logic          db_rst;
  logic          wake_evt;
  logic          trigger;

  boa_debounce #(
    .db_len      (db_len),
    .sync_stages (sync_stages)
  ) u_db_rst (
    .clk (clk),
    .rst (rst),
    .in  (btn_rst),
    .out (db_rst)
  );

`ifdef BOA_RST_WAKE_EN
  logic db_wake;
  logic wake_prev_q;

  boa_debounce #(
    .db_len      (db_len),
    .sync_stages (sync_stages)
  ) u_db_wake (
    .clk (clk),
    .rst (rst),
    .in  (btn_wake),
    .out (db_wake)
  );

  // Previous debounced wake level, for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      wake_prev_q <= 1'b0;
    end else begin
      wake_prev_q <= db_wake;
    end
  end

  // Only a fresh press while shut down counts; a held button does not retrigger.
  assign wake_evt = db_wake & ~wake_prev_q & (state_q == SHDN);
`else
  logic unused_wake;
  assign unused_wake = btn_wake;
  assign wake_evt    = 1'b0;
`endif

  assign trigger = db_rst | pmu_rst_req | wake_evt;

  // Next-state logic: any trigger wins and reloads the stretch counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (trigger) begin
      state_d = RESET;
      cnt_d   = CNT_LOAD;
      cause_d = pick_cause(pmu_rst_req, db_rst);
    end else begin
      case (state_q)
        RESET: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CNT_ONE) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (pmu_shdn_req) begin
            state_d = SHDN;
          end
        end
        SHDN: begin
          state_d = SHDN;
        end
        default: begin
          state_d = RESET;
          cnt_d   = CNT_LOAD;
        end
      endcase
    end
  end

  // State, counter, cause and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET;
      cnt_q      <= CNT_LOAD;
      cause_q    <= CAUSE_POR;
      core_rst_q <= 1'b1;
      shdn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      core_rst_q <= (state_d == RESET);
      shdn_q     <= (state_d == SHDN);
    end
  end

  assign core_rst  = core_rst_q;
  assign shdn      = shdn_q;
  assign rst_cause = cause_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_boa_rst_ctrl.sv
// Bench for boa_rst_ctrl: directed scenarios followed by random button and
// PMU activity, every cycle compared against a cycle-level behavioural model.
module tb_boa_rst_ctrl;

  localparam int RST_LEN = 3;
  localparam int DB_LEN  = 8;
  localparam int SYNC    = 2;
`ifdef BOA_RST_WAKE_EN
  localparam bit WAKE_EN = 1'b1;
`else
  localparam bit WAKE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_rst;
  logic       btn_wake;
  logic       pmu_rst_req;
  logic       pmu_shdn_req;
  logic       core_rst;
  logic       shdn;
  logic [1:0] rst_cause;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [5:0] exp_q[$];

  // Model: per-button sample history, debounced level and disagreement run,
  // cycles since the last trigger, shutdown flag and last cause.
  bit     m_line[2][$];
  bit     m_db[2];
  int     m_run[2];
  int     m_since;
  bit     m_shdn;
  bit     m_wake_prev;
  bit [1:0] m_cause;

  int rise_at;
  int fall_at;
  int seg_len;
  bit seg_b;
  bit seg_w;

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  boa_rst_ctrl #(
    .rst_len     (RST_LEN),
    .db_len      (DB_LEN),
    .sync_stages (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_rst      (btn_rst),
    .btn_wake     (btn_wake),
    .pmu_rst_req  (pmu_rst_req),
    .pmu_shdn_req (pmu_shdn_req),
    .core_rst     (core_rst),
    .shdn         (shdn),
    .rst_cause    (rst_cause),
    .state_dbg    (state_dbg)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_line[b].delete();
      for (int s = 0; s < SYNC; s++) m_line[b].push_back(1'b0);
      m_db[b]  = 1'b0;
      m_run[b] = 0;
    end
    m_since     = 0;
    m_shdn      = 1'b0;
    m_wake_prev = 1'b0;
    m_cause     = 2'b00;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit raw[2];
    bit wake_evt;
    bit trig;
    bit exp_core;
    bit [1:0] exp_state;
    raw[0] = btn_rst;
    raw[1] = btn_wake;
    if (rst) begin
      model_reset();
    end else begin
      wake_evt = WAKE_EN && m_db[1] && !m_wake_prev && m_shdn && (m_since >= RST_LEN);
      trig = m_db[0] || pmu_rst_req || wake_evt;
      if (trig) begin
        m_since = 0;
        m_shdn  = 1'b0;
        m_cause = pmu_rst_req ? 2'b10 : (m_db[0] ? 2'b01 : 2'b11);
      end else if (m_since < RST_LEN) begin
        m_since++;
      end else if (!m_shdn && pmu_shdn_req) begin
        m_shdn = 1'b1;
      end
      m_wake_prev = m_db[1];
      for (int b = 0; b < 2; b++) begin
        if (m_line[b][SYNC-1] != m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == DB_LEN) begin
            m_db[b]  = ~m_db[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_line[b].push_front(raw[b]);
        void'(m_line[b].pop_back());
      end
    end
    exp_core  = (m_since < RST_LEN);
    exp_state = exp_core ? 2'd0 : (m_shdn ? 2'd2 : 2'd1);
    exp_q.push_back({exp_core, m_shdn, m_cause, exp_state});
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, take one rising edge, then score.
  task automatic tick(input bit r, input bit b, input bit w, input bit pr, input bit ps);
    logic [5:0] e;
    rst          = r;
    btn_rst      = b;
    btn_wake     = w;
    pmu_rst_req  = pr;
    pmu_shdn_req = ps;
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    e = exp_q.pop_front();
    chk("core_rst", {7'd0, core_rst}, {7'd0, e[5]});
    chk("shdn", {7'd0, shdn}, {7'd0, e[4]});
    chk("rst_cause", {6'd0, rst_cause}, {6'd0, e[3:2]});
    chk("state_dbg", {6'd0, state_dbg}, {6'd0, e[1:0]});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; btn_rst = 1'b0; btn_wake = 1'b0;
    pmu_rst_req = 1'b0; pmu_shdn_req = 1'b0;
    model_reset();
    @(negedge clk);

    // Power-on reset and release.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("por_core_rst", {7'd0, core_rst}, 8'd1);
    chk("por_shdn", {7'd0, shdn}, 8'd0);
    chk("por_cause", {6'd0, rst_cause}, 8'd0);
    chk("por_state", {6'd0, state_dbg}, 8'd0);
    for (int i = 1; i <= RST_LEN; i++) begin
      idle(1);
      chk("release_core_rst", {7'd0, core_rst}, (i < RST_LEN) ? 8'd1 : 8'd0);
    end
    chk("release_state", {6'd0, state_dbg}, 8'd1);
    chk("release_cause", {6'd0, rst_cause}, 8'd0);

    // Short glitch on the reset button is filtered out.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      chk("glitch_core_rst", {7'd0, core_rst}, 8'd0);
    end

    // Held press: reset rises after sync+debounce+1, falls rst_len after release filter.
    rise_at = 0;
    fall_at = 0;
    for (int i = 1; i <= 45; i++) begin
      tick(1'b0, (i <= 20), 1'b0, 1'b0, 1'b0);
      if (core_rst && rise_at == 0) rise_at = i;
      if (!core_rst && rise_at != 0 && fall_at == 0) fall_at = i;
    end
    chk("btn_rise_edge", 8'(rise_at), 8'(SYNC + DB_LEN + 1));
    chk("btn_fall_edge", 8'(fall_at), 8'(20 + SYNC + DB_LEN + RST_LEN));
    chk("btn_cause", {6'd0, rst_cause}, 8'd1);

    // One-cycle shutdown request latches SHDN; PMU reset leaves it.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("shdn_next_edge", {7'd0, shdn}, 8'd1);
    idle(4);
    chk("shdn_held", {7'd0, shdn}, 8'd1);
    chk("shdn_state", {6'd0, state_dbg}, 8'd2);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pmu_rst_shdn", {7'd0, shdn}, 8'd0);
    chk("pmu_rst_core", {7'd0, core_rst}, 8'd1);
    chk("pmu_rst_cause", {6'd0, rst_cause}, 8'd2);
    idle(RST_LEN);
    chk("pmu_rst_run", {6'd0, state_dbg}, 8'd1);

    // Simultaneous reset and shutdown: reset wins, shutdown never shows.
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("both_core_rst", {7'd0, core_rst}, 8'd1);
    chk("both_shdn", {7'd0, shdn}, 8'd0);
    for (int i = 0; i < RST_LEN + 3; i++) begin
      idle(1);
      chk("both_shdn_after", {7'd0, shdn}, 8'd0);
    end

    // Wake button while shut down.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wake_pre_state", {6'd0, state_dbg}, 8'd2);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef BOA_RST_WAKE_EN
    chk("wake_cause", {6'd0, rst_cause}, 8'd3);
    chk("wake_state", {6'd0, state_dbg}, 8'd1);
`else
    chk("wake_ignored_state", {6'd0, state_dbg}, 8'd2);
    chk("wake_ignored_cause", {6'd0, rst_cause}, 8'd2);
`endif
    idle(12);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(RST_LEN);

    // Reload mid-countdown when the counter is at 1.
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= RST_LEN; i++) begin
      idle(1);
      chk("reload_core_rst", {7'd0, core_rst}, (i < RST_LEN) ? 8'd1 : 8'd0);
    end

    // Random segments of button levels with sparse PMU and power-on pulses.
    for (int seg = 0; seg < 200; seg++) begin
      seg_len = $urandom_range(1, 25);
      seg_b   = ($urandom_range(0, 3) == 0);
      seg_w   = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < seg_len; j++) begin
        tick(($urandom_range(0, 799) == 0), seg_b, seg_w,
             ($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boa_rst_ctrl.md
# boa_rst_ctrl

Reset and power sequencer for the FPGA top level. It sits directly upstream of the `main` SoC instance. It turns the raw reset button, the optional wake button and the PMU bus requests into a stretched core reset and a clock-hold shutdown signal. It adds synchronisation and debounce, a three-state sequencer, and a software-visible reset-cause register.

## Interface
Parameters:
- `rst_len`, 3: core reset length in cycles after the last trigger; must be ≥1.
- `db_len`, 12000: debounce stability window in cycles (1 ms at 12 MHz); must be ≥1.
- `sync_stages`, 2: flip-flop stages in each button synchroniser; must be ≥2.

Ports:
- `clk` in 1: system clock, the undivided board clock.
- `rst` in 1: synchronous, active-high power-on reset.
- `btn_rst` in 1: raw reset button, asynchronous, active-high.
- `btn_wake` in 1: raw wake button, asynchronous, active-high.
- `pmu_rst_req` in 1: PMU reset request, level, from `pmu_bus.rst`.
- `pmu_shdn_req` in 1: PMU shutdown request, level, from `pmu_bus.shdn`.
- `core_rst` out 1: reset to `main`, registered.
- `shdn` out 1: clock hold; the top level ORs it into the core clock.
- `rst_cause` out 2: cause of the most recent reset. 00 power-on, 01 button, 10 PMU, 11 wake.
- `state_dbg` out 2: current FSM state, exported for pmod probing.

## Operation
- Each button passes through a `sync_stages` synchroniser, then through a debouncer.
  - Debounce counter increments while the synced input differs from the debounced output.
  - The counter clears to 0 whenever the two are equal.
  - When the counter reaches `db_len`-1, the debounced output flips and the counter clears.
- Reset trigger = debounced `btn_rst` (level) OR `pmu_rst_req` OR wake event. A wake event is a debounced `btn_wake` rising edge while in SHDN, and exists only with the macro enabled.
- FSM states:
  - RESET: `core_rst`=1, `shdn`=0.
  - RUN: `core_rst`=0, `shdn`=0.
  - SHDN: `core_rst`=0, `shdn`=1.
- Transitions:
  - Trigger in any state → RESET, counter reloaded to `rst_len`.
  - RESET with no trigger: counter decrements; when counter==1, go to RUN.
  - RUN with `pmu_shdn_req` and no trigger → SHDN.
  - SHDN is left only through a trigger.
- Priority: trigger beats shutdown. Simultaneous `pmu_rst_req` and `pmu_shdn_req` gives RESET and `shdn`=0.
- Reset held: a debounced `btn_rst` or `pmu_rst_req` held high keeps the FSM in RESET, reloading every cycle.
- `rst_cause` is written on every trigger cycle. Priority when sources coincide: PMU > button > wake.
- `rst` forces: state RESET, counter=`rst_len`, `rst_cause`=00, debouncers cleared with output 0, synchronisers cleared.
- Counter width is $clog2(`rst_len`+1), so it can hold `rst_len` without truncation.

## Timing
- Reset values: `core_rst`=1, `shdn`=0, `rst_cause`=00, `state_dbg`=RESET.
- After `rst` deasserts, `core_rst` stays 1 for exactly `rst_len` more rising edges, then falls.
- Button press held stable from edge N:
  - Debounced output rises at edge N+`sync_stages`+`db_len`.
  - `core_rst` is re-asserted one edge later.
- Glitch shorter than `db_len` cycles: no effect; the counter clears.
- `pmu_rst_req` or `pmu_shdn_req` takes effect on the next edge (1-cycle latency, no debounce).
- Release of reset: `core_rst` falls `rst_len` edges after the last trigger cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `BOA_RST_WAKE_EN`.
- Defined: a debounced `btn_wake` rising edge in SHDN is a trigger with cause 11. In RESET and RUN the wake button has no effect.
- Undefined: `btn_wake` is ignored, and its synchroniser and debouncer are not instantiated. SHDN is exited only by button or PMU reset. Cause 11 never occurs.

## Structure
- Package `boa_rst_pkg`:
  - `rst_state_t` enum: RESET=0, RUN=1, SHDN=2.
  - `rst_cause_t` enum: 2-bit encodings above.
- Sub-module `boa_debounce`:
  - Contains the synchroniser and the debounce counter.
  - Parameters `db_len` and `sync_stages`; ports `clk`, `rst`, `in`, `out`.
  - Instantiated once per button.

## Test plan
- `rst` high 5 cycles then low, `rst_len`=3 → `core_rst` falls on the 3rd edge after deassertion; `rst_cause`=00; `state_dbg`=RUN.
- `db_len`=8: `btn_rst` pulse of 5 cycles → no reset. `btn_rst` held 20 cycles → `core_rst` rises 2+8+1 edges after press onset, `rst_cause`=01, falls 3 edges after the debounced output drops.
- In RUN, `pmu_shdn_req` for 1 cycle → `shdn`=1 next edge and stays after the request drops. Then `pmu_rst_req` → `shdn`=0 and `core_rst`=1 next edge, `rst_cause`=10.
- `pmu_rst_req` and `pmu_shdn_req` asserted in the same cycle → RESET, `shdn` never asserts.
- With `BOA_RST_WAKE_EN`, in SHDN: hold `btn_wake` → RESET after the debounce window, `rst_cause`=11. Without the macro, the same stimulus leaves the FSM in SHDN.
- `pmu_rst_req` asserted mid-countdown (counter=1) → counter reloaded to 3, and `core_rst` stays high 3 more edges.
